// File: rtl/nubus_pkg.sv
// Shared types and status codes for the NuBus slave sequencer.
package nubus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } slave_state_t;

  // Active-low encoded {TM1*, TM0*} status driven during ACK
  localparam logic [1:0] ST_COMPLETE = 2'b11;
  localparam logic [1:0] ST_ERROR    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_TRYAGAIN = 2'b00;

endpackage

// File: rtl/nubus_wait_timer.sv
// Saturating WAIT-cycle counter with minimum-wait and timeout flags.
// Timeout flag is only built when NUBUS_SLAVE_TIMEOUT_EN is defined.
module nubus_wait_timer #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic ge_min_o,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WAIT);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q equals the number of WAIT edges already taken, so the flags are
  // evaluated combinationally against the registered count
  assign ge_min_o = (count_q >= MIN_C);

`ifdef NUBUS_SLAVE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  assign timeout_o = (count_q == TIMEOUT_C);
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/nubus_slave_seq.sv
// NuBus slave sequencer: IDLE -> WAIT -> ACK with status code on TM1*/TM0*.
// Timeout abort path built only when NUBUS_SLAVE_TIMEOUT_EN is defined.
module nubus_slave_seq
  import nubus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MIN_WAIT = 1,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              nub_clkn,
  input  logic              nub_resetn,
  input  logic              nub_startn,
  input  logic              nub_ackn,
  input  logic              nub_tm1n,
  input  logic              nub_tm0n,
  input  logic [ADDR_W-1:0] nub_adn,
  input  logic              myslot,
  input  logic              mem_ready,
  input  logic              mem_err,
  input  logic              mem_busy,
  output logic              slave_o,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_abort_o,
  output logic              ack_o,
  output logic              tm_oe_o,
  output logic              tm1n_o,
  output logic              tm0n_o
);

  slave_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic wr_q, wr_d;
  logic size_q, size_d;
  logic rdy_seen_q, rdy_seen_d;
  logic err_q, err_d;
  logic req_q, slave_q, ack_q, abort_q, abort_d;
  logic [1:0] tm_q, status_d;
  logic clr, en, ge_min, timeout;
  logic addr_cycle, ready_now, err_now;

  nubus_wait_timer #(
    .CNT_W   (CNT_W),
    .MIN_WAIT(MIN_WAIT),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (nub_clkn),
    .rst_ni   (nub_resetn),
    .clr_i    (clr),
    .en_i     (en),
    .ge_min_o (ge_min),
    .timeout_o(timeout)
  );

  assign addr_cycle = !nub_startn && nub_ackn && myslot;
  // Ready seen earlier (held off by MIN_WAIT) keeps the error captured then
  assign ready_now  = rdy_seen_q || mem_ready;
  assign err_now    = rdy_seen_q ? err_q : mem_err;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    size_d     = size_q;
    rdy_seen_d = rdy_seen_q;
    err_d      = err_q;
    status_d   = ST_COMPLETE;
    abort_d    = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (addr_cycle) begin
          addr_d = ~nub_adn;
          wr_d   = ~nub_tm1n;
          size_d = ~nub_tm0n;
          if (mem_busy) begin
            state_d  = ACK;
            status_d = ST_TRYAGAIN;
          end else begin
            state_d    = WAIT;
            clr        = 1'b1;
            rdy_seen_d = 1'b0;
            err_d      = 1'b0;
          end
        end
      end
      WAIT: begin
        en = 1'b1;
        if (mem_ready && !rdy_seen_q) begin
          rdy_seen_d = 1'b1;
          err_d      = mem_err;
        end
        if (ready_now && ge_min) begin
          state_d  = ACK;
          status_d = err_now ? ST_ERROR : ST_COMPLETE;
        end
`ifdef NUBUS_SLAVE_TIMEOUT_EN
        else if (timeout) begin
          state_d  = ACK;
          status_d = ST_TIMEOUT;
          abort_d  = 1'b1;
        end
`endif
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      size_q     <= 1'b0;
      rdy_seen_q <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      slave_q    <= 1'b0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
      tm_q       <= ST_COMPLETE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      size_q     <= size_d;
      rdy_seen_q <= rdy_seen_d;
      err_q      <= err_d;
      req_q      <= (state_d == WAIT);
      slave_q    <= (state_d != IDLE);
      ack_q      <= (state_d == ACK);
      abort_q    <= abort_d;
      tm_q       <= (state_d == ACK) ? status_d : ST_COMPLETE;
    end
  end

  assign slave_o     = slave_q;
  assign mem_req_o   = req_q;
  assign mem_write_o = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_abort_o = abort_q;
  assign ack_o       = ack_q;
  assign tm_oe_o     = ack_q;
  assign tm1n_o      = tm_q[1];
  assign tm0n_o      = tm_q[0];

endmodule

// File: tb/tb_nubus_slave_seq.sv
// Scoreboard bench for nubus_slave_seq (MIN_WAIT=2, TIMEOUT=16).
module tb_nubus_slave_seq;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MIN_WAIT = 2;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned CNT_W    = 8;

  logic clk = 1'b0;
  logic nub_resetn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic [ADDR_W-1:0] nub_adn;
  logic myslot, mem_ready, mem_err, mem_busy;
  logic slave_o, mem_req_o, mem_write_o, mem_abort_o, ack_o, tm_oe_o, tm1n_o, tm0n_o;
  logic [ADDR_W-1:0] mem_addr_o;

  always #5 clk = ~clk;

  nubus_slave_seq #(
    .ADDR_W  (ADDR_W),
    .MIN_WAIT(MIN_WAIT),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .nub_clkn   (clk),
    .nub_resetn (nub_resetn),
    .nub_startn (nub_startn),
    .nub_ackn   (nub_ackn),
    .nub_tm1n   (nub_tm1n),
    .nub_tm0n   (nub_tm0n),
    .nub_adn    (nub_adn),
    .myslot     (myslot),
    .mem_ready  (mem_ready),
    .mem_err    (mem_err),
    .mem_busy   (mem_busy),
    .slave_o    (slave_o),
    .mem_req_o  (mem_req_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o (mem_addr_o),
    .mem_abort_o(mem_abort_o),
    .ack_o      (ack_o),
    .tm_oe_o    (tm_oe_o),
    .tm1n_o     (tm1n_o),
    .tm0n_o     (tm0n_o)
  );

  typedef struct {
    int          lat;
    logic [1:0]  status;
    logic        wr;
    logic [31:0] addr;
    logic        abort;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  logic [31:0] last_addr = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    nub_tm1n   = 1'b1;
    nub_tm0n   = 1'b1;
    nub_adn    = '1;
    myslot     = 1'b0;
    mem_ready  = 1'b0;
    mem_err    = 1'b0;
    mem_busy   = 1'b0;
  endtask

  // r: WAIT cycle index in which mem_ready first rises (-1 = never)
  task automatic do_xfer(input string name, input logic [31:0] addr, input logic wr,
                         input logic busy, input int r, input int rlen, input logic err);
    exp_t e, g;
    int n, top;
    bit got, req_bad, abort_early;
    e.addr  = addr;
    e.wr    = wr;
    e.abort = 1'b0;
    top = (r > int'(MIN_WAIT)) ? r : int'(MIN_WAIT);
    if (busy) begin
      e.lat = 1; e.status = 2'b00;
    end else begin
      e.lat = top + 2; e.status = err ? 2'b10 : 2'b11;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
      if (r < 0 || top > int'(TIMEOUT)) begin
        e.lat = int'(TIMEOUT) + 2; e.status = 2'b01; e.abort = 1'b1;
      end
`endif
    end
    sb.push_back(e);

    mem_busy   = busy;
    nub_adn    = ~addr;
    nub_tm1n   = ~wr;
    nub_tm0n   = 1'b0;
    myslot     = 1'b1;
    nub_ackn   = 1'b1;
    nub_startn = 1'b0;
    step();
    nub_startn = 1'b1;
    myslot     = 1'b0;
    mem_busy   = 1'b0;
    nub_adn    = $urandom;
    last_addr  = addr;

    checks++;
    if (mem_addr_o !== addr || mem_write_o !== wr)
      $display("FAIL %s latch: addr %h wr %b, want addr %h wr %b", name, mem_addr_o, mem_write_o, addr, wr);
    else passes++;

    n = 0; got = 0; req_bad = 0; abort_early = 0;
    while (!got && n < 400) begin
      if (ack_o === 1'b1) got = 1;
      else begin
        if (mem_req_o !== ~busy) req_bad = 1;
        if (mem_abort_o !== 1'b0) abort_early = 1;
        mem_ready = (r >= 0) && (n >= r) && (n < r + rlen);
        mem_err   = mem_ready & err;
        step();
        n++;
      end
    end

    checks++;
    if (!got) begin
      $display("FAIL %s ack_wait: no ack_o within %0d cycles", name, n);
      void'(sb.pop_front());
    end else begin
      passes++;
      g = sb.pop_front();
      checks++;
      if (n + 1 !== g.lat) $display("FAIL %s latency: got %0d want %0d", name, n + 1, g.lat);
      else passes++;
      checks++;
      if ({tm1n_o, tm0n_o} !== g.status)
        $display("FAIL %s status: got %b want %b", name, {tm1n_o, tm0n_o}, g.status);
      else passes++;
      checks++;
      if (mem_abort_o !== g.abort || abort_early)
        $display("FAIL %s abort: got %b (early %0d) want %b", name, mem_abort_o, abort_early, g.abort);
      else passes++;
      checks++;
      if ({mem_req_o, tm_oe_o, slave_o} !== 3'b011 || req_bad)
        $display("FAIL %s req_oe: got req %b oe %b slave %b (req_bad %0d) want 0 1 1",
                 name, mem_req_o, tm_oe_o, slave_o, req_bad);
      else passes++;
    end

    mem_ready = 1'b0;
    mem_err   = 1'b0;
    step();
    checks++;
    if ({slave_o, ack_o, tm_oe_o, tm1n_o, tm0n_o, mem_abort_o} !== 6'b000110)
      $display("FAIL %s ack_one_cycle: got %b want 000110", name,
               {slave_o, ack_o, tm_oe_o, tm1n_o, tm0n_o, mem_abort_o});
    else passes++;
  endtask

  task automatic test_reset();
    idle_inputs();
    nub_resetn = 1'b0;
    step();
    step();
    checks++;
    if ({slave_o, mem_req_o, mem_write_o, mem_abort_o, ack_o, tm_oe_o, tm1n_o, tm0n_o} !== 8'b00000011)
      $display("FAIL reset_ctrl: got %b want 00000011",
               {slave_o, mem_req_o, mem_write_o, mem_abort_o, ack_o, tm_oe_o, tm1n_o, tm0n_o});
    else passes++;
    checks++;
    if (mem_addr_o !== '0) $display("FAIL reset_addr: got %h want 0", mem_addr_o);
    else passes++;
    nub_resetn = 1'b1;
    step();
  endtask

  task automatic test_read();
    do_xfer("read", 32'h0000_0100, 1'b0, 1'b0, 0, 1000, 1'b0);
  endtask

  task automatic test_write_err();
    do_xfer("write_err", 32'h2000_0040, 1'b1, 1'b0, 5, 1000, 1'b1);
  endtask

  task automatic test_held_off();
    do_xfer("held_off", 32'h0000_0ABC, 1'b0, 1'b0, 1, 1, 1'b1);
  endtask

  task automatic test_busy();
    do_xfer("busy", 32'h1234_5678, 1'b1, 1'b1, -1, 0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef NUBUS_SLAVE_TIMEOUT_EN
    do_xfer("timeout", 32'h0000_0200, 1'b0, 1'b0, -1, 0, 1'b0);
    do_xfer("ready_at_timeout", 32'h0000_0204, 1'b0, 1'b0, int'(TIMEOUT), 1000, 1'b0);
`else
    do_xfer("no_timeout", 32'h0000_0200, 1'b0, 1'b0, 40, 1000, 1'b0);
`endif
  endtask

  task automatic test_no_response();
    bit bad;
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      nub_adn    = ~32'hDEAD_0000;
      nub_tm1n   = 1'b0;
      myslot     = (k == 1);
      nub_ackn   = (k == 0);
      nub_startn = 1'b0;
      mem_ready  = 1'b1;
      step();
      idle_inputs();
      for (int c = 0; c < 6; c++) begin
        if (slave_o !== 1'b0 || ack_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== last_addr)
          bad = 1;
        step();
      end
      checks++;
      if (bad) $display("FAIL no_response_%0d: slave %b ack %b req %b addr %h want 0 0 0 %h",
                        k, slave_o, ack_o, mem_req_o, mem_addr_o, last_addr);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    do_xfer("b2b_a", 32'h0000_1000, 1'b1, 1'b0, 0, 1000, 1'b0);
    do_xfer("b2b_b", 32'h0000_2000, 1'b0, 1'b0, 3, 1000, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit bad;
    nub_adn    = ~32'h0000_3000;
    nub_tm1n   = 1'b1;
    myslot     = 1'b1;
    nub_startn = 1'b0;
    step();
    idle_inputs();
    step();
    step();
    nub_resetn = 1'b0;
    step();
    checks++;
    if ({slave_o, mem_req_o, mem_write_o, mem_abort_o, ack_o, tm_oe_o, tm1n_o, tm0n_o} !== 8'b00000011
        || mem_addr_o !== '0)
      $display("FAIL reset_mid: got %b addr %h want 00000011 addr 0",
               {slave_o, mem_req_o, mem_write_o, mem_abort_o, ack_o, tm_oe_o, tm1n_o, tm0n_o}, mem_addr_o);
    else passes++;
    nub_resetn = 1'b1;
    mem_ready  = 1'b1;
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      if (ack_o !== 1'b0 || mem_abort_o !== 1'b0 || slave_o !== 1'b0) bad = 1;
      step();
    end
    mem_ready = 1'b0;
    checks++;
    if (bad) $display("FAIL reset_mid_silent: ack %b abort %b slave %b want 0 0 0", ack_o, mem_abort_o, slave_o);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_err();
    test_held_off();
    test_busy();
    test_no_response();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nubus_slave_seq.md
# nubus_slave_seq

Parametrised NuBus slave sequencer, successor to the fixed slave PAL state machine. Latches address and transfer mode in the address cycle, runs a local memory handshake with programmable minimum wait states, and ends every addressed transaction with exactly one ACK cycle carrying a NuBus status code. The status code is complete, error, timeout or try-again-later. Sits between the NuBus pad logic and the card's memory/ROM decode.

## Interface

- ADDR_W, 32: width of latched address bus
- MIN_WAIT, 1: minimum WAIT cycles before ACK may be issued (0..2^CNT_W-1)
- TIMEOUT, 255: WAIT cycles after which the transfer is aborted; must be > MIN_WAIT
- CNT_W, 8: wait/timeout counter width; must hold TIMEOUT

- nub_clkn  in  1  NuBus clock; all logic on rising edge
- nub_resetn  in  1  reset, synchronous, active-low
- nub_startn  in  1  START*, active-low
- nub_ackn  in  1  ACK* as seen on bus, active-low
- nub_tm1n, nub_tm0n  in  1 each  TM1*/TM0*; TM1*=1 means read
- nub_adn  in  ADDR_W  AD* bus, active-low
- myslot  in  1  address decodes to this card (valid in START cycle)
- mem_ready  in  1  memory has data / accepted write
- mem_err  in  1  qualifies mem_ready: access failed
- mem_busy  in  1  card cannot accept a transfer now
- slave_o  out  1  transaction in progress (WAIT or ACK)
- mem_req_o  out  1  memory request, high throughout WAIT
- mem_write_o  out  1  latched ~TM1*
- mem_addr_o  out  ADDR_W  latched ~AD*
- mem_abort_o  out  1  one-cycle pulse on timeout
- ack_o  out  1  drive ACK* low (pad inverts); high only in ACK
- tm_oe_o  out  1  drive TM1*/TM0* status; equals ack_o
- tm1n_o, tm0n_o  out  1 each  status code, active-low encoded

## Operation

- States: IDLE, WAIT, ACK.
- Address cycle = nub_startn=0 & nub_ackn=1 & myslot=1, in IDLE.
- Address cycle, mem_busy=1: latch the address fields. Go to ACK with status TRYAGAIN. No mem_req_o.
- Address cycle, mem_busy=0: latch mem_addr_o, mem_write_o and the tm0 size bit. Clear the counter. Go to WAIT.
- WAIT: the counter increments each cycle and saturates.
  - mem_ready=1 and count>=MIN_WAIT: go to ACK with status ERROR if mem_err, else COMPLETE.
  - mem_ready while count<MIN_WAIT is held off: ACK is issued at count=MIN_WAIT. The err value is captured when ready is first seen.
  - count==TIMEOUT without ready: pulse mem_abort_o and go to ACK with status TIMEOUT. Ready in the same cycle as timeout wins.
- ACK: lasts exactly one cycle, then IDLE.
- START is ignored outside IDLE.
- START with ACK low (attention cycle) is ignored in all states.
- Status encoding (tm1n_o,tm0n_o): COMPLETE=11, ERROR=10, TIMEOUT=01, TRYAGAIN=00. Outputs hold 11 when tm_oe_o=0.

## Timing

- Reset (nub_resetn=0 at an edge) forces IDLE.
- Reset values: slave_o=0, mem_req_o=0, mem_write_o=0, mem_addr_o=0, mem_abort_o=0, ack_o=0, tm_oe_o=0, tm1n_o=1, tm0n_o=1.
- Reset mid-transfer aborts silently: no ACK, no mem_abort_o.
- All outputs are registered.
- Latency from address cycle edge to ack_o=1:
  - MIN_WAIT+2 cycles minimum with immediate ready.
  - 1 cycle for TRYAGAIN.
  - TIMEOUT+2 cycles for timeout.
- mem_req_o falls in the same edge ack_o rises.
- Back-to-back: a new address cycle is accepted in the first IDLE cycle after ACK.

## Configuration

- NUBUS_SLAVE_TIMEOUT_EN defined: the timeout path, mem_abort_o pulse and TIMEOUT status are built.
- NUBUS_SLAVE_TIMEOUT_EN undefined: WAIT lasts until mem_ready. The counter only enforces MIN_WAIT and saturates. mem_abort_o is tied 0. The TIMEOUT parameter is ignored.

## Structure

- Package nubus_pkg holds:
  - state enum slave_state_t {IDLE, WAIT, ACK}
  - 2-bit status constants ST_COMPLETE, ST_ERROR, ST_TIMEOUT, ST_TRYAGAIN
- Sub-module nubus_wait_timer: counter with clear, enable, saturation, ge_min and timeout outputs. It is instantiated once.

## Test plan

- MIN_WAIT=2, read at AD=~0x0000_0100 with myslot, ready tied 1.
  - Expected: mem_addr_o=0x100, mem_write_o=0, ack_o high 4 cycles after START, status 11, one cycle only.
- Write with mem_ready at WAIT cycle 5 and mem_err=1.
  - Expected: ack_o the next cycle, status 10, mem_write_o=1.
- mem_busy=1 at START.
  - Expected: mem_req_o never high, ack_o on next cycle, status 00.
- TIMEOUT=16, ready never asserted, macro defined.
  - Expected: mem_abort_o pulses at WAIT count 16, ACK status 01.
- Same as above with the macro undefined.
  - Expected: no ack_o until ready arrives at cycle 40, then status 11.
- Boundary conditions:
  - START with myslot=0: no response.
  - START with ACK low: no response.
  - nub_resetn low during WAIT: next cycle all outputs at reset values and no ACK.
